// File: rtl/numbers_rom.sv
// numbers_rom: registered seven-segment glyph pixels for ten 30x30 decimal digits
module numbers_rom #(
  parameter int ADDR_WIDTH = 32,
  parameter int NUM_DIGITS = 10
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] address,
  output logic                  q
);
  // segment enables per digit as {a,b,c,d,e,f,g}, digit 0 in the low slot; unused slots stay dark
  localparam logic [111:0] SEG_TAB = {
    42'd0,
    7'b1111011, 7'b1111111, 7'b1110000, 7'b1011111, 7'b1011011,
    7'b0110011, 7'b1111001, 7'b1101101, 7'b0110000, 7'b1111110
  };
  localparam logic [ADDR_WIDTH-1:0] LIMIT = ADDR_WIDTH'(NUM_DIGITS * 900);
  logic        in_range;
  logic [13:0] a14;
  logic [27:0] dprod;
  logic [3:0]  digit;
  logic [9:0]  pix;
  logic [20:0] rprod;
  logic [4:0]  r;
  logic [4:0]  c;
  logic [6:0]  seg_idx;
  logic [6:0]  segs;
  logic [6:0]  hit;
  logic        lit;
  // reciprocal-multiply decode: 18642/2^24 and 2185/2^16 are exact floors for every in-range address
  always_comb begin
    in_range = address < LIMIT;
    a14      = address[13:0];
    dprod    = 28'(a14) * 28'd18642;
    digit    = 4'(dprod >> 24);
    pix      = 10'(a14 - 14'(digit) * 14'd900);
    rprod    = 21'(pix) * 21'd2185;
    r        = 5'(rprod >> 16);
    c        = 5'(pix - 10'(r) * 10'd30);
    seg_idx  = 7'(digit) * 7'd7;
    segs     = SEG_TAB[seg_idx +: 7];
    hit[6]   = (r >= 5'd2)  && (r <= 5'd5)  && (c >= 5'd7)  && (c <= 5'd22);
    hit[5]   = (r >= 5'd2)  && (r <= 5'd15) && (c >= 5'd19) && (c <= 5'd22);
    hit[4]   = (r >= 5'd14) && (r <= 5'd27) && (c >= 5'd19) && (c <= 5'd22);
    hit[3]   = (r >= 5'd24) && (r <= 5'd27) && (c >= 5'd7)  && (c <= 5'd22);
    hit[2]   = (r >= 5'd14) && (r <= 5'd27) && (c >= 5'd7)  && (c <= 5'd10);
    hit[1]   = (r >= 5'd2)  && (r <= 5'd15) && (c >= 5'd7)  && (c <= 5'd10);
    hit[0]   = (r >= 5'd13) && (r <= 5'd16) && (c >= 5'd7)  && (c <= 5'd22);
    lit      = in_range && |(segs & hit);
  end
  // one-cycle registered read, reset wins so an undriven address cannot reach q
  always_ff @(posedge clock) begin
    if (reset) q <= 1'b0;
    else q <= lit;
  end
endmodule

// File: tb/tb_numbers_rom.sv
// tb_numbers_rom: scoreboard bench for the glyph store
module tb_numbers_rom;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] address = '0;
  logic        q;
  int          passed = 0;
  int          total = 0;
  logic        sb[$];
  logic        exp_q;

  numbers_rom dut (.clock(clock), .reset(reset), .address(address), .q(q));

  always #5 clock = ~clock;

  function automatic logic ref_q(input logic [31:0] a);
    int d, p, r, c;
    string s;
    logic v;
    if (a >= 32'd9000) return 1'b0;
    d = int'(a) / 900;
    p = int'(a) % 900;
    r = p / 30;
    c = p % 30;
    case (d)
      0: s = "abcdef";
      1: s = "bc";
      2: s = "abdeg";
      3: s = "abcdg";
      4: s = "bcfg";
      5: s = "acdfg";
      6: s = "acdefg";
      7: s = "abc";
      8: s = "abcdefg";
      default: s = "abcdfg";
    endcase
    v = 1'b0;
    for (int i = 0; i < s.len(); i++) begin
      case (s[i])
        "a": v |= (r >= 2 && r <= 5 && c >= 7 && c <= 22);
        "b": v |= (r >= 2 && r <= 15 && c >= 19 && c <= 22);
        "c": v |= (r >= 14 && r <= 27 && c >= 19 && c <= 22);
        "d": v |= (r >= 24 && r <= 27 && c >= 7 && c <= 22);
        "e": v |= (r >= 14 && r <= 27 && c >= 7 && c <= 10);
        "f": v |= (r >= 2 && r <= 15 && c >= 7 && c <= 10);
        "g": v |= (r >= 13 && r <= 16 && c >= 7 && c <= 22);
        default: v |= 1'b0;
      endcase
    end
    return v;
  endfunction

  task automatic push(input logic [31:0] a, input logic e);
    @(negedge clock);
    address = a;
    sb.push_back(e);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    push(32'd7635, 1'b0);
    @(posedge clock); #1;
    exp_q = sb.pop_front();
    total++;
    if (q !== exp_q) $display("FAIL reset_hold q=%b expected=%b", q, exp_q); else passed++;
    @(negedge clock);
    address = 'x;
    sb.push_back(1'b0);
    @(posedge clock); #1;
    exp_q = sb.pop_front();
    total++;
    if (q !== exp_q) $display("FAIL reset_x_addr q=%b expected=%b", q, exp_q); else passed++;
    @(negedge clock);
    reset = 1'b0;
    address = 32'd7635;
    sb.push_back(1'b1);
    @(posedge clock); #1;
    exp_q = sb.pop_front();
    total++;
    if (q !== exp_q) $display("FAIL reset_release q=%b expected=%b", q, exp_q); else passed++;
  endtask

  task automatic test_digit1();
    logic [31:0] addrs [3] = '{32'd968, 32'd980, 32'd1335};
    logic        exps  [3] = '{1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 3; i++) begin
      push(addrs[i], exps[i]);
      @(posedge clock); #1;
      exp_q = sb.pop_front();
      total++;
      if (q !== exp_q) $display("FAIL digit1 addr=%0d q=%b expected=%b", addrs[i], q, exp_q); else passed++;
    end
  endtask

  task automatic test_centre();
    logic exps [10] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    for (int d = 0; d < 10; d++) begin
      push(32'(d * 900 + 435), exps[d]);
      @(posedge clock); #1;
      exp_q = sb.pop_front();
      total++;
      if (q !== exp_q) $display("FAIL centre digit=%0d q=%b expected=%b", d, q, exp_q); else passed++;
    end
  endtask

  task automatic test_borders();
    logic [31:0] addrs [6] = '{32'd0, 32'd29, 32'd870, 32'd899, 32'd7200, 32'd7267};
    logic        exps  [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 6; i++) begin
      push(addrs[i], exps[i]);
      @(posedge clock); #1;
      exp_q = sb.pop_front();
      total++;
      if (q !== exp_q) $display("FAIL border addr=%0d q=%b expected=%b", addrs[i], q, exp_q); else passed++;
    end
  endtask

  task automatic test_out_of_range();
    logic [31:0] addrs [5] = '{32'd7635, 32'd9000, 32'd9899, 32'hFFFF_FFFF, 32'd8999};
    logic        exps  [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 5; i++) begin
      push(addrs[i], exps[i]);
      @(posedge clock); #1;
      exp_q = sb.pop_front();
      total++;
      if (q !== exp_q) $display("FAIL range addr=%0d q=%b expected=%b", addrs[i], q, exp_q); else passed++;
    end
  endtask

  task automatic test_back_to_back();
    int errs = 0;
    for (int a = 0; a < 9000; a++) begin
      push(32'(a), ref_q(32'(a)));
      @(posedge clock); #1;
      exp_q = sb.pop_front();
      total++;
      if (q !== exp_q) begin
        if (errs < 20) $display("FAIL sweep addr=%0d q=%b expected=%b", a, q, exp_q);
        errs++;
      end else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_digit1();
    test_centre();
    test_borders();
    test_out_of_range();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/numbers_rom.md
Name: numbers_rom

Overview:
Synchronous read-only glyph store for the on-screen countdown digits. It returns one pixel bit per address for ten decimal digits. Each digit is a 30x30 monochrome cell stored row-major at 900 addresses per digit. The display logic forms the address as `digit*900 + row*30 + col` and reads one registered bit per clock, so glyphs are generated from fixed seven-segment geometry rather than loaded from a memory file.

Parameters:
- ADDR_WIDTH, 32, width of the address input.
- NUM_DIGITS, 10, number of glyphs (digits 0..NUM_DIGITS-1). The cell size is fixed at 30x30.

Ports:
- clock  input  1  sole clock; all state updates on its rising edge. The display block drives it with its inverted pixel clock.
- reset  input  1  synchronous, active-high reset.
- address  input  ADDR_WIDTH  linear pixel address, unsigned.
- q  output  1  registered pixel value; 1 = lit (foreground), 0 = background.

Behaviour:
- Reset: synchronous, active-high. On a rising edge with reset=1, q <= 0. Reset has priority over any read. No other state exists.
- Read latency: exactly 1 cycle. q after edge N reflects the address sampled at edge N. No enable and no handshake; a new read occurs every cycle.
- Decode, unsigned:
  - digit = address / 900
  - pix = address % 900
  - r = pix / 30 (0..29, top to bottom)
  - c = pix % 30 (0..29, left to right)
- Out of range: address >= NUM_DIGITS*900 (8999 is the last valid address) gives q <= 0. The full ADDR_WIDTH is compared, with no truncation or wrap.
- Segment rectangles, rows and columns inclusive:
  - a: r 2..5, c 7..22
  - b: r 2..15, c 19..22
  - c: r 14..27, c 19..22
  - d: r 24..27, c 7..22
  - e: r 14..27, c 7..10
  - f: r 2..15, c 7..10
  - g: r 13..16, c 7..22
- Pixel value: lit if it lies inside any rectangle of a segment enabled for that digit. Overlaps are OR'ed. Everything else, including rows 0..1 and 28..29 and columns 0..6 and 23..29, is 0.
- Segment sets per digit:
  - 0: abcdef
  - 1: bc
  - 2: abdeg
  - 3: abcdg
  - 4: bcfg
  - 5: acdfg
  - 6: acdefg
  - 7: abc
  - 8: abcdefg
  - 9: abcdfg
- Division and modulo by 900 and 30 may use any combinational method (constant compare/subtract, multiply-by-reciprocal) as long as the 1-cycle latency holds for every address.
- Output is purely a function of the last sampled address. X/Z on address while reset=1 must not affect q.

Test Plan:
- Reset: reset=1, address=7635 for one edge -> q=0. Release reset with the same address -> q=1 after the next edge (digit 8, r14 c15, segment g).
- Digit 1 columns: address 968 (r2 c8) -> q=0. Address 980 (r2 c20) -> q=1. Address 1335 (r14 c15) -> q=0.
- Centre pixel across digits: address d*900+435 for d=0..9 -> q = 0,0,1,1,1,1,1,0,1,1 (segment g membership). Each value appears one cycle after its address.
- Borders and corners: addresses 0, 29, 870, 899 and 7200 -> q=0. Address 7267 (digit 8, r2 c7) -> q=1.
- Out of range: addresses 9000, 9899 and 0xFFFFFFFF -> q=0. Address 8999 (digit 9, r29 c29) -> q=0.
- Back-to-back streaming: sweep addresses 0..8999 one per cycle and compare against a reference model of the segment table. Every q must match with exactly 1-cycle latency and no bubbles.
